// File: rtl/seq_combo_lock_pkg.sv
// Shared constants for the sequential combination lock: FSM state codes,
// 7-segment display patterns (active-low, bit order {g,f,e,d,c,b,a}) and
// a helper that maps a state code to its display pattern.
package seq_combo_lock_pkg;

    // FSM state codes, visible on the lock_state output
    localparam logic [2:0] ST_IDLE   = 3'b000;
    localparam logic [2:0] ST_ENTRY  = 3'b001;
    localparam logic [2:0] ST_OPEN   = 3'b010;
    localparam logic [2:0] ST_ALARM  = 3'b011;
    localparam logic [2:0] ST_CHANGE = 3'b101;

    // Active-low segment patterns
    localparam logic [6:0] SEG_DASH   = 7'b0111111;  // '-'
    localparam logic [6:0] SEG_OPEN   = 7'b1000000;  // 'O'
    localparam logic [6:0] SEG_ALARM  = 7'b0001000;  // 'A'
    localparam logic [6:0] SEG_CHANGE = 7'b0101011;  // 'n'

    // Display pattern for a given state; unknown codes show a dash
    function automatic logic [6:0] seg_for_state(input logic [2:0] st);
        logic [6:0] seg;
        case (st)
            ST_OPEN:   seg = SEG_OPEN;
            ST_ALARM:  seg = SEG_ALARM;
            ST_CHANGE: seg = SEG_CHANGE;
            default:   seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seq_combo_lock_key_pulse.sv
// Button conditioning for one raw active-low pushbutton: two-flop
// synchroniser followed by a falling-edge detector. A press yields a single
// one-cycle pulse that appears on the third clock edge after the press,
// no matter how long the button is held.
module key_pulse (
    input  logic clk,
    input  logic reset,
    input  logic button_n,
    output logic pulse
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;
    logic pulse_reg;

    // Synchronise the button, keep one delayed copy, register the 1->0 edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            prev_reg  <= 1'b1;
            pulse_reg <= 1'b0;
        end else begin
            sync1_reg <= button_n;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            pulse_reg <= prev_reg & ~sync2_reg;
        end
    end

    assign pulse = pulse_reg;

endmodule

// File: rtl/seq_combo_lock.sv
// Sequential combination lock. Digits are entered one per enter press and
// compared as a whole code once NUM_DIGITS have been collected; the first
// entered digit lands in the most-significant slot. Too many consecutive
// failures raise the alarm. From OPEN the code can be changed.
// Build option: define LOCKOUT_TIMER_EN to make ALARM expire after
// LOCKOUT_CYCLES clocks; otherwise ALARM is left only through reset.
module seq_combo_lock
    import seq_combo_lock_pkg::*;
#(
    parameter int                              DIGIT_W        = 4,
    parameter int                              NUM_DIGITS     = 4,
    parameter int                              MAX_TRIES      = 3,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0]   DEFAULT_CODE   = {NUM_DIGITS{DIGIT_W'(6)}},
    parameter int                              LOCKOUT_CYCLES = 50_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               enter_n,
    input  logic               change_n,
    output logic [2:0]         lock_state,
    output logic               unlocked,
    output logic               alarm,
    output logic [2:0]         digit_cnt,
    output logic [3:0]         fail_cnt,
    output logic [6:0]         hex_n
);

    localparam int CODE_W = NUM_DIGITS * DIGIT_W;

    logic [1:0] button_n_bus;
    logic [1:0] pulse_bus;
    logic       enter_p;
    logic       change_p;

    logic [2:0]        state_reg,     state_next;
    logic [CODE_W-1:0] code_reg,      code_next;
    logic [CODE_W-1:0] entry_buf_reg, entry_buf_next;
    logic [2:0]        digit_cnt_reg, digit_cnt_next;
    logic [3:0]        fail_cnt_reg,  fail_cnt_next;

    logic [CODE_W-1:0] shifted;
    logic              last_digit;
    logic [4:0]        fail_inc;
    logic              lockout_done;

    // Bit 0 is the enter button, bit 1 the change button
    assign button_n_bus = {change_n, enter_n};

    for (genvar gi = 0; gi < 2; gi++) begin : g_key
        key_pulse u_key (
            .clk      (clk),
            .reset    (reset),
            .button_n (button_n_bus[gi]),
            .pulse    (pulse_bus[gi])
        );
    end

    assign enter_p  = pulse_bus[0];
    assign change_p = pulse_bus[1];

    // Buffer as it would look with the current digit appended
    assign shifted    = (entry_buf_reg << DIGIT_W) | CODE_W'(digit);
    assign last_digit = (digit_cnt_reg == 3'(NUM_DIGITS - 1));
    assign fail_inc   = {1'b0, fail_cnt_reg} + 5'd1;

`ifdef LOCKOUT_TIMER_EN
    localparam int TIMER_W = $clog2(LOCKOUT_CYCLES + 1);

    logic [TIMER_W-1:0] lockout_reg;

    // Count clocks spent in ALARM; cleared whenever the FSM is elsewhere
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lockout_reg <= '0;
        end else if (state_reg == ST_ALARM && !lockout_done) begin
            lockout_reg <= lockout_reg + TIMER_W'(1);
        end else begin
            lockout_reg <= '0;
        end
    end

    assign lockout_done = (state_reg == ST_ALARM) &&
                          (lockout_reg == TIMER_W'(LOCKOUT_CYCLES - 1));
`else
    // Never true for a legal LOCKOUT_CYCLES: ALARM holds until reset
    assign lockout_done = (LOCKOUT_CYCLES < 0);
`endif

    // Next-state logic; an enter pulse always wins over a simultaneous change
    always_comb begin
        state_next     = state_reg;
        code_next      = code_reg;
        entry_buf_next = entry_buf_reg;
        digit_cnt_next = digit_cnt_reg;
        fail_cnt_next  = fail_cnt_reg;

        case (state_reg)
            ST_IDLE, ST_ENTRY: begin
                if (enter_p) begin
                    if (last_digit) begin
                        entry_buf_next = '0;
                        digit_cnt_next = '0;
                        if (shifted == code_reg) begin
                            state_next    = ST_OPEN;
                            fail_cnt_next = '0;
                        end else if (fail_inc < 5'(MAX_TRIES)) begin
                            state_next    = ST_IDLE;
                            fail_cnt_next = fail_inc[3:0];
                        end else begin
                            state_next    = ST_ALARM;
                            fail_cnt_next = 4'(MAX_TRIES);
                        end
                    end else begin
                        entry_buf_next = shifted;
                        digit_cnt_next = digit_cnt_reg + 3'd1;
                        state_next     = ST_ENTRY;
                    end
                end else if (change_p && state_reg == ST_ENTRY) begin
                    entry_buf_next = '0;
                    digit_cnt_next = '0;
                    state_next     = ST_IDLE;
                end
            end
            ST_OPEN: begin
                if (enter_p) begin
                    state_next = ST_IDLE;
                end else if (change_p) begin
                    state_next     = ST_CHANGE;
                    entry_buf_next = '0;
                    digit_cnt_next = '0;
                end
            end
            ST_CHANGE: begin
                if (enter_p) begin
                    if (last_digit) begin
                        code_next      = shifted;
                        entry_buf_next = '0;
                        digit_cnt_next = '0;
                        state_next     = ST_IDLE;
                    end else begin
                        entry_buf_next = shifted;
                        digit_cnt_next = digit_cnt_reg + 3'd1;
                    end
                end else if (change_p) begin
                    entry_buf_next = '0;
                    digit_cnt_next = '0;
                    state_next     = ST_OPEN;
                end
            end
            ST_ALARM: begin
                if (lockout_done) begin
                    state_next    = ST_IDLE;
                    fail_cnt_next = '0;
                end
            end
            default: begin
                state_next     = ST_IDLE;
                entry_buf_next = '0;
                digit_cnt_next = '0;
            end
        endcase
    end

    // State, stored code and entry progress registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            code_reg      <= DEFAULT_CODE;
            entry_buf_reg <= '0;
            digit_cnt_reg <= '0;
            fail_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            code_reg      <= code_next;
            entry_buf_reg <= entry_buf_next;
            digit_cnt_reg <= digit_cnt_next;
            fail_cnt_reg  <= fail_cnt_next;
        end
    end

    assign lock_state = state_reg;
    assign unlocked   = (state_reg == ST_OPEN);
    assign alarm      = (state_reg == ST_ALARM);
    assign digit_cnt  = digit_cnt_reg;
    assign fail_cnt   = fail_cnt_reg;
    assign hex_n      = seg_for_state(state_reg);

endmodule

// File: tb/tb_seq_combo_lock.sv
// Testbench for seq_combo_lock: directed scenarios plus a randomized run,
// all checked against a digit-queue model of the lock's rules.
// Honours LOCKOUT_TIMER_EN the same way the design does.
module tb_seq_combo_lock;

    localparam int ND = 4;
    localparam int MT = 3;
    localparam int LC = 10;

    localparam int M_IDLE   = 0;
    localparam int M_ENTRY  = 1;
    localparam int M_OPEN   = 2;
    localparam int M_ALARM  = 3;
    localparam int M_CHANGE = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] digit = 4'h0;
    logic       enter_n = 1'b1;
    logic       change_n = 1'b1;
    logic [2:0] lock_state;
    logic       unlocked;
    logic       alarm;
    logic [2:0] digit_cnt;
    logic [3:0] fail_cnt;
    logic [6:0] hex_n;

    seq_combo_lock #(
        .DIGIT_W        (4),
        .NUM_DIGITS     (ND),
        .MAX_TRIES      (MT),
        .DEFAULT_CODE   (16'h6666),
        .LOCKOUT_CYCLES (LC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digit      (digit),
        .enter_n    (enter_n),
        .change_n   (change_n),
        .lock_state (lock_state),
        .unlocked   (unlocked),
        .alarm      (alarm),
        .digit_cnt  (digit_cnt),
        .fail_cnt   (fail_cnt),
        .hex_n      (hex_n)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int txn = 0;

    // Reference model: stored code as digits, digits typed so far, failures
    int          m_state;
    int unsigned m_code[ND];
    int unsigned m_entry[$];
    int          m_fail;

    wire [18:0] obs_vec = {lock_state, unlocked, alarm, digit_cnt, fail_cnt, hex_n};

    task automatic model_reset();
        m_state = M_IDLE;
        for (int i = 0; i < ND; i++) m_code[i] = 6;
        m_entry.delete();
        m_fail = 0;
    endtask

    task automatic model_enter(input int unsigned d);
        bit ok;
        case (m_state)
            M_IDLE, M_ENTRY: begin
                m_entry.push_back(d);
                if (m_entry.size() == ND) begin
                    ok = 1'b1;
                    for (int i = 0; i < ND; i++) if (m_entry[i] != m_code[i]) ok = 1'b0;
                    if (ok) begin
                        m_state = M_OPEN;
                        m_fail = 0;
                    end else if (m_fail + 1 < MT) begin
                        m_state = M_IDLE;
                        m_fail = m_fail + 1;
                    end else begin
                        m_state = M_ALARM;
                        m_fail = MT;
                    end
                    m_entry.delete();
                end else begin
                    m_state = M_ENTRY;
                end
            end
            M_OPEN: m_state = M_IDLE;
            M_CHANGE: begin
                m_entry.push_back(d);
                if (m_entry.size() == ND) begin
                    for (int i = 0; i < ND; i++) m_code[i] = m_entry[i];
                    m_entry.delete();
                    m_state = M_IDLE;
                end
            end
            default: ;
        endcase
    endtask

    task automatic model_change();
        case (m_state)
            M_ENTRY:  begin m_entry.delete(); m_state = M_IDLE;   end
            M_OPEN:   begin m_entry.delete(); m_state = M_CHANGE; end
            M_CHANGE: begin m_entry.delete(); m_state = M_OPEN;   end
            default: ;
        endcase
    endtask

    // Expected {lock_state, unlocked, alarm, digit_cnt, fail_cnt, hex_n}
    function automatic logic [18:0] exp_vec();
        logic [2:0] st;
        logic [6:0] hx;
        case (m_state)
            M_ENTRY:  begin st = 3'b001; hx = 7'b0111111; end
            M_OPEN:   begin st = 3'b010; hx = 7'b1000000; end
            M_ALARM:  begin st = 3'b011; hx = 7'b0001000; end
            M_CHANGE: begin st = 3'b101; hx = 7'b0101011; end
            default:  begin st = 3'b000; hx = 7'b0111111; end
        endcase
        return {st, (m_state == M_OPEN), (m_state == M_ALARM),
                3'(m_entry.size()), 4'(m_fail), hx};
    endfunction

    // One button transaction: press, hold, release, let the pulse settle
    task automatic press(input bit e, input bit c, input logic [3:0] d, input int hold);
        @(negedge clk);
        digit = d;
        enter_n = !e;
        change_n = !c;
        repeat (hold) @(negedge clk);
        enter_n = 1'b1;
        change_n = 1'b1;
        repeat (6) @(negedge clk);
        if (e) model_enter(d);
        else if (c) model_change();
        txn++;
        $display("txn %0d: enter=%0d change=%0d digit=%h hold=%0d -> state=%b cnt=%0d fail=%0d hex=%b",
                 txn, e, c, d, hold, lock_state, digit_cnt, fail_cnt, hex_n);
    endtask

    // Asynchronous reset in the middle of a clock phase; checked while low
    task automatic apply_reset(input string tag);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs_vec !== {3'b000, 1'b0, 1'b0, 3'd0, 4'd0, 7'b0111111}) begin
            errors++;
            $display("FAIL reset_%s: got=%h required=%h", tag, obs_vec,
                     {3'b000, 1'b0, 1'b0, 3'd0, 4'd0, 7'b0111111});
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        txn++;
        $display("txn %0d: reset (%s) -> state=%b cnt=%0d fail=%0d", txn, tag, lock_state, digit_cnt, fail_cnt);
    endtask

    task automatic test_reset();
        apply_reset("initial");
        checks++;
        if (obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL reset_released: got=%h required=%h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_open();
        apply_reset("open");
        for (int i = 0; i < ND; i++) begin
            press(1'b1, 1'b0, 4'h6, 2);
            checks++;
            if (obs_vec !== exp_vec()) begin
                errors++;
                $display("FAIL open_digit%0d: got=%h required=%h", i, obs_vec, exp_vec());
            end
        end
        checks++;
        if ({unlocked, hex_n} !== {1'b1, 7'b1000000}) begin
            errors++;
            $display("FAIL open_outputs: got unlocked=%b hex=%b required unlocked=1 hex=1000000", unlocked, hex_n);
        end
    endtask

    task automatic test_alarm();
        apply_reset("alarm");
        for (int a = 0; a < MT; a++) begin
            for (int i = 0; i < ND; i++) press(1'b1, 1'b0, 4'(i + 1), 1);
            checks++;
            if (obs_vec !== exp_vec()) begin
                errors++;
                $display("FAIL alarm_attempt%0d: got=%h required=%h", a, obs_vec, exp_vec());
            end
        end
        checks++;
        if ({alarm, fail_cnt} !== {1'b1, 4'(MT)}) begin
            errors++;
            $display("FAIL alarm_raised: got alarm=%b fail=%0d required alarm=1 fail=%0d", alarm, fail_cnt, MT);
        end
`ifndef LOCKOUT_TIMER_EN
        press(1'b1, 1'b0, 4'h6, 1);
        press(1'b0, 1'b1, 4'h0, 1);
        press(1'b1, 1'b1, 4'h6, 1);
        checks++;
        if (obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL alarm_ignores_buttons: got=%h required=%h", obs_vec, exp_vec());
        end
`endif
        apply_reset("from_alarm");
    endtask

    task automatic test_change();
        logic [3:0] nc [ND];
        nc[0] = 4'h9; nc[1] = 4'h8; nc[2] = 4'h7; nc[3] = 4'h6;
        apply_reset("change");
        for (int i = 0; i < ND; i++) press(1'b1, 1'b0, 4'h6, 1);
        press(1'b0, 1'b1, 4'h0, 2);
        checks++;
        if (obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL change_enter: got=%h required=%h", obs_vec, exp_vec());
        end
        for (int i = 0; i < ND; i++) press(1'b1, 1'b0, nc[i], 1);
        checks++;
        if (obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL change_stored: got=%h required=%h", obs_vec, exp_vec());
        end
        for (int i = 0; i < ND; i++) press(1'b1, 1'b0, 4'h6, 1);
        checks++;
        if ({lock_state, fail_cnt} !== {3'b000, 4'd1} || obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL change_old_code_rejected: got=%h required=%h", obs_vec, exp_vec());
        end
        for (int i = 0; i < ND; i++) press(1'b1, 1'b0, nc[i], 1);
        checks++;
        if ({lock_state, fail_cnt} !== {3'b010, 4'd0} || obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL change_new_code_opens: got=%h required=%h", obs_vec, exp_vec());
        end
        // Abort a change: code must stay 9876
        press(1'b0, 1'b1, 4'h0, 1);
        press(1'b1, 1'b0, 4'h1, 1);
        press(1'b0, 1'b1, 4'h0, 1);
        checks++;
        if (obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL change_abort: got=%h required=%h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_simultaneous();
        apply_reset("simultaneous");
        press(1'b0, 1'b1, 4'h0, 1);
        checks++;
        if (obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL change_in_idle_ignored: got=%h required=%h", obs_vec, exp_vec());
        end
        press(1'b1, 1'b0, 4'h1, 1);
        press(1'b1, 1'b0, 4'h2, 1);
        press(1'b1, 1'b1, 4'h3, 2);
        checks++;
        if ({lock_state, digit_cnt} !== {3'b001, 3'd3} || obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL both_buttons: got=%h required=%h", obs_vec, exp_vec());
        end
        press(1'b0, 1'b1, 4'h0, 1);
        checks++;
        if (obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL entry_abort: got=%h required=%h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_hold();
        apply_reset("hold");
        press(1'b1, 1'b0, 4'h5, 100);
        checks++;
        if (digit_cnt !== 3'd1 || obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL held_button: got=%h required=%h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_reset_in_change();
        apply_reset("pre_change");
        for (int i = 0; i < ND; i++) press(1'b1, 1'b0, 4'h6, 1);
        press(1'b0, 1'b1, 4'h0, 1);
        press(1'b1, 1'b0, 4'h1, 1);
        press(1'b1, 1'b0, 4'h2, 1);
        apply_reset("mid_change");
        for (int i = 0; i < ND; i++) press(1'b1, 1'b0, 4'h6, 1);
        checks++;
        if (unlocked !== 1'b1 || obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL default_code_after_reset: got=%h required=%h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_lockout();
        int n;
        apply_reset("lockout");
        for (int a = 0; a < MT - 1; a++)
            for (int i = 0; i < ND; i++) press(1'b1, 1'b0, 4'h1, 1);
        for (int i = 0; i < ND - 1; i++) press(1'b1, 1'b0, 4'h1, 1);
        @(negedge clk);
        digit = 4'h1;
        enter_n = 1'b0;
        n = 0;
        while (!alarm && n < 20) begin
            @(negedge clk);
            n++;
        end
        enter_n = 1'b1;
        model_enter(4'h1);
        checks++;
        if (alarm !== 1'b1) begin
            errors++;
            $display("FAIL alarm_reached: got alarm=%b after %0d cycles required alarm=1", alarm, n);
        end
`ifdef LOCKOUT_TIMER_EN
        n = 0;
        while (alarm && n < 200) begin
            @(negedge clk);
            n++;
        end
        m_state = M_IDLE;
        m_fail = 0;
        checks++;
        if (n !== LC || obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL lockout_expiry: got cycles=%0d vec=%h required cycles=%0d vec=%h", n, obs_vec, LC, exp_vec());
        end
        txn++;
        $display("txn %0d: alarm expired after %0d cycles -> state=%b fail=%0d", txn, n, lock_state, fail_cnt);
`else
        repeat (1000) @(negedge clk);
        checks++;
        if (alarm !== 1'b1 || obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL alarm_sticky: got=%h required=%h", obs_vec, exp_vec());
        end
        txn++;
        $display("txn %0d: alarm held for 1000 cycles -> state=%b", txn, lock_state);
`endif
        apply_reset("after_lockout");
    endtask

    task automatic test_random();
        int r;
        logic [3:0] d;
        apply_reset("random");
        for (int k = 0; k < 200; k++) begin
            if (m_state == M_ALARM) apply_reset("random_alarm");
            r = $urandom_range(0, 9);
            if ((m_state == M_IDLE || m_state == M_ENTRY) && $urandom_range(0, 2) != 0)
                d = 4'(m_code[m_entry.size()]);
            else
                d = 4'($urandom_range(0, 15));
            press(r <= 6 || r == 9, r >= 7, d, $urandom_range(1, 4));
            checks++;
            if (obs_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random_txn%0d: got=%h required=%h", k, obs_vec, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_open();
        test_alarm();
        test_change();
        test_simultaneous();
        test_hold();
        test_reset_in_change();
        test_lockout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
